// File: rtl/spmm_pkg.sv
// Dimensions and element types shared with the SpMM core.
// lhs_csr_packer and its buffer build their port widths from these values.
package spmm_pkg;
    localparam int N       = 16;
    localparam int W       = 8;
    localparam int LG_N    = $clog2(N);
    localparam int DB_LG_N = 2 * LG_N;
    localparam int NN      = N * N;
    localparam int CNT_W   = DB_LG_N + 1;

    typedef logic [W-1:0]       data_t;
    typedef logic [LG_N-1:0]    idx_t;
    typedef logic [DB_LG_N-1:0] ptr_t;
    typedef logic [CNT_W-1:0]   cnt_t;
endpackage

// File: rtl/nz_buffer.sv
// Holds one matrix of {col, data} entries.
// N banks of N words let one registered read return a whole N-wide beat.
module nz_buffer
    import spmm_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  ptr_t                   wr_addr,
    input  idx_t                   wr_col,
    input  data_t                  wr_data,
    input  logic                   rd_en,
    input  idx_t                   rd_beat,
    input  cnt_t                   nnz,
    output logic [N-1:0][LG_N-1:0] rd_col,
    output logic [N-1:0][W-1:0]    rd_data
);

    // Entry e lives in bank e%N at word e/N, so beat k is word k of every bank.
    for (genvar gi = 0; gi < N; gi++) begin : g_bank
        logic [LG_N+W-1:0] mem [N];
        logic [LG_N+W-1:0] q_reg;
        cnt_t              lane_idx;

        assign lane_idx = cnt_t'({rd_beat, idx_t'(gi)});

        always_ff @(posedge clock) begin
            if (wr_en && (wr_addr[LG_N-1:0] == idx_t'(gi))) begin
                mem[wr_addr[DB_LG_N-1:LG_N]] <= {wr_col, wr_data};
            end
        end

        // Lanes past the end of the matrix read as zero, hiding stale words.
        always_ff @(posedge clock) begin
            if (reset) begin
                q_reg <= '0;
            end else if (rd_en && (lane_idx < nnz)) begin
                q_reg <= mem[rd_beat];
            end else begin
                q_reg <= '0;
            end
        end

        assign rd_col[gi]  = q_reg[LG_N+W-1:W];
        assign rd_data[gi] = q_reg[W-1:0];
    end

endmodule

// File: rtl/lhs_csr_packer.sv
// Collects a row-sorted nonzero stream into one matrix, builds per-row end
// pointers, then streams a start beat plus N-wide data beats to SpMM's LHS port.
module lhs_csr_packer
    import spmm_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      nz_valid,
    output logic                      nz_ready,
    input  logic [LG_N-1:0]           nz_row,
    input  logic [LG_N-1:0]           nz_col,
    input  logic [W-1:0]              nz_data,
    input  logic                      nz_last,
    input  logic                      mat_end,
    input  logic                      lhs_ready,
    output logic                      lhs_start,
    output logic [N-1:0][DB_LG_N-1:0] lhs_ptr,
    output logic [N-1:0][LG_N-1:0]    lhs_col,
    output logic [N-1:0][W-1:0]       lhs_data,
    output logic                      lhs_busy,
    output logic                      err
);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_PREFIX,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t                    state_reg;
    logic                      nz_ready_reg;
    logic                      lhs_start_reg;
    logic                      lhs_busy_reg;
    logic                      err_reg;
    logic                      ready_seen_reg;
    cnt_t                      nnz_reg;
    cnt_t                      cum_reg;
    idx_t                      prev_row_reg;
    idx_t                      idx_reg;
    idx_t                      beat_reg;
    cnt_t                      row_cnt_reg [N];
    ptr_t                      ptr_reg [N];
    logic [N-1:0][DB_LG_N-1:0] lhs_ptr_reg;

    logic accept;
    logic drop;
    logic keep;
    logic mat_done;
    logic go;
    logic last_beat_hit;
    logic rd_en;
    idx_t last_beat;
    idx_t rd_beat;
    cnt_t nnz_m1;
    cnt_t cum_next;

    always_comb begin
        accept        = nz_valid && nz_ready_reg;
        drop          = accept && ((nnz_reg == cnt_t'(NN)) || (nz_row < prev_row_reg));
        keep          = accept && !drop;
        // A dropped last entry does not close the matrix; mat_end must follow.
        mat_done      = (keep && nz_last) || (nz_ready_reg && mat_end && !nz_valid);
        nnz_m1        = nnz_reg - cnt_t'(1);
        last_beat     = (nnz_reg == '0) ? '0 : idx_t'(nnz_m1 >> LG_N);
        last_beat_hit = (beat_reg == last_beat);
        go            = (state_reg == S_WAIT) && (ready_seen_reg || lhs_ready);
        rd_en         = go || ((state_reg == S_STREAM) && !last_beat_hit);
        rd_beat       = go ? '0 : beat_reg + idx_t'(1);
        cum_next      = cum_reg + row_cnt_reg[idx_reg];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= S_COLLECT;
            nz_ready_reg   <= 1'b0;
            lhs_start_reg  <= 1'b0;
            lhs_busy_reg   <= 1'b0;
            err_reg        <= 1'b0;
            ready_seen_reg <= 1'b0;
            nnz_reg        <= '0;
            cum_reg        <= '0;
            prev_row_reg   <= '0;
            idx_reg        <= '0;
            beat_reg       <= '0;
            for (int r = 0; r < N; r++) begin
                row_cnt_reg[r] <= '0;
                ptr_reg[r]     <= '0;
                lhs_ptr_reg[r] <= '0;
            end
        end else begin
            lhs_start_reg <= 1'b0;
            if (lhs_ready) begin
                ready_seen_reg <= 1'b1;
            end
            if (drop) begin
                err_reg <= 1'b1;
            end
            if (keep) begin
                nnz_reg              <= nnz_reg + cnt_t'(1);
                prev_row_reg         <= nz_row;
                row_cnt_reg[nz_row]  <= row_cnt_reg[nz_row] + cnt_t'(1);
            end

            case (state_reg)
                S_COLLECT: begin
                    nz_ready_reg <= 1'b1;
                    if (mat_done) begin
                        state_reg    <= S_PREFIX;
                        nz_ready_reg <= 1'b0;
                        lhs_busy_reg <= 1'b1;
                        idx_reg      <= '0;
                        cum_reg      <= '0;
                    end
                end

                // One row per cycle; an empty prefix wraps to all-ones.
                S_PREFIX: begin
                    cum_reg          <= cum_next;
                    ptr_reg[idx_reg] <= ptr_t'(cum_next - cnt_t'(1));
                    idx_reg          <= idx_reg + idx_t'(1);
                    if (idx_reg == idx_t'(N - 1)) begin
                        state_reg <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (go) begin
                        state_reg      <= S_STREAM;
                        lhs_start_reg  <= 1'b1;
                        ready_seen_reg <= 1'b0;
                        beat_reg       <= '0;
                        for (int r = 0; r < N; r++) begin
                            lhs_ptr_reg[r] <= ptr_reg[r];
                        end
                    end
                end

                S_STREAM: begin
                    if (last_beat_hit) begin
                        state_reg    <= S_COLLECT;
                        nz_ready_reg <= 1'b1;
                        lhs_busy_reg <= 1'b0;
                        nnz_reg      <= '0;
                        cum_reg      <= '0;
                        prev_row_reg <= '0;
                        for (int r = 0; r < N; r++) begin
                            row_cnt_reg[r] <= '0;
                        end
                    end else begin
                        beat_reg <= beat_reg + idx_t'(1);
                    end
                end

                default: state_reg <= S_COLLECT;
            endcase
        end
    end

    nz_buffer u_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (keep),
        .wr_addr (ptr_t'(nnz_reg)),
        .wr_col  (nz_col),
        .wr_data (nz_data),
        .rd_en   (rd_en),
        .rd_beat (rd_beat),
        .nnz     (nnz_reg),
        .rd_col  (lhs_col),
        .rd_data (lhs_data)
    );

    assign nz_ready  = nz_ready_reg;
    assign lhs_start = lhs_start_reg;
    assign lhs_ptr   = lhs_ptr_reg;
    assign lhs_busy  = lhs_busy_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_lhs_csr_packer.sv
// Self-checking bench for lhs_csr_packer: directed table, hand sequences for
// reset and row-order corners, and randomized matrices against a CSR model.
module tb_lhs_csr_packer;
    import spmm_pkg::*;

    typedef logic [N-1:0][DB_LG_N-1:0] ptr_vec_t;
    typedef logic [N-1:0][LG_N-1:0]    col_vec_t;
    typedef logic [N-1:0][W-1:0]       data_vec_t;

    typedef struct packed {
        logic [N-1:0][8:0] cnt;
        ptr_vec_t          ptr;
        int                beats;
        int                extra;
        int                ready_delay;
        bit                use_last;
        bit                exp_err;
    } vec_t;

    logic      clock = 1'b0;
    logic      reset = 1'b1;
    logic      nz_valid = 1'b0;
    logic      nz_last = 1'b0;
    logic      mat_end = 1'b0;
    logic      lhs_ready = 1'b0;
    idx_t      nz_row = '0;
    idx_t      nz_col = '0;
    data_t     nz_data = '0;
    logic      nz_ready;
    logic      lhs_start;
    logic      lhs_busy;
    logic      err;
    ptr_vec_t  lhs_ptr;
    col_vec_t  lhs_col;
    data_vec_t lhs_data;

    always #5 clock = ~clock;

    lhs_csr_packer dut (
        .clock     (clock),
        .reset     (reset),
        .nz_valid  (nz_valid),
        .nz_ready  (nz_ready),
        .nz_row    (nz_row),
        .nz_col    (nz_col),
        .nz_data   (nz_data),
        .nz_last   (nz_last),
        .mat_end   (mat_end),
        .lhs_ready (lhs_ready),
        .lhs_start (lhs_start),
        .lhs_ptr   (lhs_ptr),
        .lhs_col   (lhs_col),
        .lhs_data  (lhs_data),
        .lhs_busy  (lhs_busy),
        .err       (err)
    );

    int   errors = 0;
    int   checks = 0;
    bit   model_err = 1'b0;
    bit   last_kept;
    int   q_row[$];
    int   q_col[$];
    int   q_data[$];
    int   k_col[$];
    int   k_data[$];
    int   k_cnt[N];
    vec_t tbl [6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, required event never seen", name);
    endtask

    // Reference: an entry survives only if the matrix has room and its row
    // does not go backwards; survivors are packed in arrival order.
    task automatic model_matrix();
        int prev = 0;
        k_col.delete();
        k_data.delete();
        for (int r = 0; r < N; r++) k_cnt[r] = 0;
        last_kept = 1'b0;
        foreach (q_row[i]) begin
            if (k_col.size() == N * N || q_row[i] < prev) begin
                model_err = 1'b1;
                last_kept = 1'b0;
            end else begin
                k_col.push_back(q_col[i]);
                k_data.push_back(q_data[i]);
                k_cnt[q_row[i]]++;
                prev = q_row[i];
                last_kept = 1'b1;
            end
        end
    endtask

    task automatic push(input idx_t r, input idx_t c, input data_t d, input logic last);
        int t = 0;
        nz_valid = 1'b1; nz_row = r; nz_col = c; nz_data = d; nz_last = last;
        while (!nz_ready && t < 200) begin @(negedge clock); t++; end
        if (!nz_ready) tmo("push_ready");
        @(negedge clock);
        nz_valid = 1'b0; nz_last = 1'b0;
    endtask

    task automatic drive_matrix(input bit use_last);
        int t = 0;
        for (int i = 0; i < q_row.size(); i++)
            push(idx_t'(q_row[i]), idx_t'(q_col[i]), data_t'(q_data[i]),
                 use_last && (i == q_row.size() - 1));
        if (!(use_last && q_row.size() > 0 && last_kept)) begin
            mat_end = 1'b1;
            while (!nz_ready && t < 200) begin @(negedge clock); t++; end
            if (!nz_ready) tmo("mat_end_ready");
            @(negedge clock);
            mat_end = 1'b0;
        end
    endtask

    // Entered one cycle after the matrix end was taken.
    task automatic run_stream(input int ready_delay, output ptr_vec_t got_ptr, output int got_beats);
        ptr_vec_t  eptr;
        col_vec_t  ecol;
        data_vec_t edata;
        int cum = 0;
        int nb;
        int t = 0;
        int k = 0;
        int idx;
        int exp_lat;
        for (int r = 0; r < N; r++) begin
            cum += k_cnt[r];
            eptr[r] = DB_LG_N'(cum - 1);
        end
        nb = (k_col.size() == 0) ? 1 : (k_col.size() + N - 1) / N;
        exp_lat = (ready_delay + 1 > N + 1) ? ready_delay + 1 : N + 1;
        got_ptr = '0;
        got_beats = 0;
        check("busy_after_end", 256'({nz_ready, lhs_busy}), 256'(2'b01));
        repeat (ready_delay) @(negedge clock);
        lhs_ready = 1'b1;
        @(negedge clock);
        lhs_ready = 1'b0;
        while (!lhs_start && t < 200) begin @(negedge clock); t++; end
        check("start_latency", 256'(ready_delay + 1 + t), 256'(exp_lat));
        if (!lhs_start) return;
        got_ptr = lhs_ptr;
        check("ptr", 256'(lhs_ptr), 256'(eptr));
        while (lhs_busy && k < 40) begin
            for (int j = 0; j < N; j++) begin
                idx = k * N + j;
                ecol[j]  = (idx < k_col.size()) ? LG_N'(k_col[idx]) : '0;
                edata[j] = (idx < k_col.size()) ? W'(k_data[idx]) : '0;
            end
            check($sformatf("beat%0d_col", k), 256'(lhs_col), 256'(ecol));
            check($sformatf("beat%0d_data", k), 256'(lhs_data), 256'(edata));
            check($sformatf("beat%0d_start", k), 256'(lhs_start), 256'(k == 0));
            if (k > 0) check($sformatf("beat%0d_ptr_hold", k), 256'(lhs_ptr), 256'(eptr));
            k++;
            @(negedge clock);
        end
        got_beats = k;
        check("beat_count", 256'(k), 256'(nb));
        check("idle_ctl", 256'({nz_ready, lhs_busy, lhs_start}), 256'(3'b100));
        check("idle_beat_zero", 256'({lhs_col, lhs_data}), 256'(0));
        check("err_flag", 256'(err), 256'(model_err));
    endtask

    task automatic load_table_entries(input vec_t v);
        int idx = 0;
        q_row.delete(); q_col.delete(); q_data.delete();
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < int'(v.cnt[r]); j++) begin
                q_row.push_back(r);
                q_col.push_back((r + j) % N);
                q_data.push_back((idx + 1) % 256);
                idx++;
            end
        end
        for (int e = 0; e < v.extra; e++) begin
            q_row.push_back(N - 1); q_col.push_back(0); q_data.push_back(8'hAA);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_err = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ptr_vec_t gp;
        ptr_vec_t hand_ptr;
        int       gb;
        int       t;
        int       n;
        int       r;

        // Directed table: row counts in, pointers / beat count / err out.
        for (int v = 0; v < 6; v++) tbl[v] = '0;
        for (int i = 0; i < N; i++) begin
            tbl[0].cnt[i] = 9'd1;                tbl[0].ptr[i] = 8'(i);
            tbl[1].ptr[i] = (i < 2) ? 8'd4 : 8'd19;
            tbl[2].ptr[i] = 8'hFF;
            tbl[3].ptr[i] = (i < 7) ? 8'hFF : 8'd2;
            tbl[4].cnt[i] = 9'd16;               tbl[4].ptr[i] = 8'(16 * i + 15);
            tbl[5].cnt[i] = 9'd16;               tbl[5].ptr[i] = 8'(16 * i + 15);
        end
        tbl[1].cnt[0] = 9'd5; tbl[1].cnt[2] = 9'd15; tbl[3].cnt[7] = 9'd3;
        tbl[0].beats = 1;  tbl[0].ready_delay = N + 2; tbl[0].use_last = 1'b1;
        tbl[1].beats = 2;  tbl[1].ready_delay = 5;     tbl[1].use_last = 1'b1;
        tbl[2].beats = 1;  tbl[2].ready_delay = 0;     tbl[2].use_last = 1'b0;
        tbl[3].beats = 1;  tbl[3].ready_delay = 2;     tbl[3].use_last = 1'b1;
        tbl[4].beats = 16; tbl[4].ready_delay = 1;     tbl[4].use_last = 1'b0;
        tbl[5].beats = 16; tbl[5].ready_delay = 3;     tbl[5].use_last = 1'b1;
        tbl[5].extra = 1;  tbl[5].exp_err = 1'b1;

        repeat (3) @(negedge clock);
        check("reset_ctl", 256'({nz_ready, lhs_start, lhs_busy, err}), 256'(0));
        check("reset_beat", 256'({lhs_ptr, lhs_col, lhs_data}), 256'(0));
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_reset", 256'(nz_ready), 256'(1));

        for (int v = 0; v < 6; v++) begin
            load_table_entries(tbl[v]);
            model_matrix();
            drive_matrix(tbl[v].use_last);
            run_stream(tbl[v].ready_delay, gp, gb);
            check($sformatf("tbl%0d_ptr", v), 256'(gp), 256'(tbl[v].ptr));
            check($sformatf("tbl%0d_beats", v), 256'(gb), 256'(tbl[v].beats));
            check($sformatf("tbl%0d_err", v), 256'(err), 256'(tbl[v].exp_err));
        end

        // Reset during beat 1 of a 4-beat stream.
        do_reset();
        check("err_cleared", 256'(err), 256'(0));
        q_row.delete(); q_col.delete(); q_data.delete();
        for (int i = 0; i < 64; i++) begin
            q_row.push_back(i / 4); q_col.push_back(i % N); q_data.push_back(i + 7);
        end
        model_matrix();
        drive_matrix(1'b1);
        lhs_ready = 1'b1;
        t = 0;
        while (!lhs_start && t < 200) begin @(negedge clock); t++; end
        lhs_ready = 1'b0;
        if (!lhs_start) tmo("midstream_start");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_ctl", 256'({nz_ready, lhs_start, lhs_busy, err}), 256'(0));
        check("midreset_beat", 256'({lhs_ptr, lhs_col, lhs_data}), 256'(0));
        reset = 1'b0;
        model_err = 1'b0;
        @(negedge clock);
        check("midreset_ready", 256'(nz_ready), 256'(1));
        q_row = '{0, 0, 1, 9};
        q_col = '{3, 5, 7, 2};
        q_data = '{11, 22, 33, 44};
        model_matrix();
        drive_matrix(1'b1);
        run_stream(4, gp, gb);

        // Row order violation: row 1 after row 3 is dropped, err sticks.
        do_reset();
        q_row = '{3, 3, 1, 4, 5};
        q_col = '{0, 1, 2, 3, 4};
        q_data = '{10, 11, 12, 13, 14};
        model_matrix();
        drive_matrix(1'b1);
        check("violation_err", 256'(err), 256'(1));
        for (int i = 0; i < N; i++)
            hand_ptr[i] = (i < 3) ? 8'hFF : (i == 3) ? 8'd1 : (i == 4) ? 8'd2 : 8'd3;
        run_stream(0, gp, gb);
        check("violation_ptr", 256'(gp), 256'(hand_ptr));
        check("violation_beats", 256'(gb), 256'(1));

        // Randomized matrices.
        do_reset();
        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(0, 40);
            r = 0;
            q_row.delete(); q_col.delete(); q_data.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) r += $urandom_range(1, 3);
                if (r > N - 1) r = N - 1;
                q_row.push_back(r);
                q_col.push_back($urandom_range(0, N - 1));
                q_data.push_back($urandom_range(0, 255));
            end
            if (n > 2 && $urandom_range(0, 3) == 0) q_row[$urandom_range(1, n - 1)] = $urandom_range(0, N - 1);
            model_matrix();
            drive_matrix(1'($urandom_range(0, 1)));
            run_stream($urandom_range(0, N + 4), gp, gb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
